// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: round-robin arbitrated controller for a bank of 8-bit
// level-sensitive latch words. A write runs SETUP -> STROBE -> HOLD, so D is
// stable around every enable pulse. A read registers the selected word's Q.
// Optional build macro: LATCH_BANK_VERIFY_EN adds a VERIFY state that reads
// back the written word and sets a sticky err flag on mismatch.
module latch_bank_ctrl #(
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2,
  parameter int EN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_a,
  input  logic                   we_a,
  input  logic [ADDR_W-1:0]      addr_a,
  input  logic [7:0]             wdata_a,
  output logic                   gnt_a,
  output logic                   done_a,
  input  logic                   req_b,
  input  logic                   we_b,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [7:0]             wdata_b,
  output logic                   gnt_b,
  output logic                   done_b,
  output logic [7:0]             rdata,
  output logic [7:0]             mem_D,
  output logic [NUM_WORDS-1:0]   mem_E,
  input  logic [8*NUM_WORDS-1:0] mem_Q,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_READ,
`ifdef LATCH_BANK_VERIFY_EN
    S_ACK,
    S_VERIFY
`else
    S_ACK
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner_b;   // 1 = current access belongs to B
  logic                  r_last_b;    // 1 = last grant went to B
  logic [ADDR_W-1:0]     r_addr;
  logic [7:0]            r_wdata;
  logic [3:0]            r_cnt;
  logic                  r_gnt_a;
  logic                  r_gnt_b;
  logic [7:0]            r_rdata;
  logic [7:0]            r_mem_d;
  logic [NUM_WORDS-1:0]  w_mem_e;
  logic                  w_any;
  logic                  w_pick_a;
  logic                  w_win_we;
  logic [ADDR_W-1:0]     w_win_addr;
  logic [7:0]            w_win_wdata;

  // Select word a from the concatenated latch outputs; out-of-range reads 0.
  function automatic logic [7:0] word_sel(input logic [8*NUM_WORDS-1:0] q,
                                          input logic [ADDR_W-1:0] a);
    logic [7:0] w;
    w = 8'h00;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (a == ADDR_W'(k)) w = q[8*k +: 8];
    end
    return w;
  endfunction

  // On a tie the requester that was not granted last time wins.
  assign w_any       = req_a || req_b;
  assign w_pick_a    = req_a && (!req_b || r_last_b);
  assign w_win_we    = w_pick_a ? we_a    : we_b;
  assign w_win_addr  = w_pick_a ? addr_a  : addr_b;
  assign w_win_wdata = w_pick_a ? wdata_a : wdata_b;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic and the enable decode (only in STROBE, only in range).
  always_comb begin
    w_next  = r_state;
    w_mem_e = '0;
    case (r_state)
      S_IDLE:   if (w_any) w_next = w_win_we ? S_SETUP : S_READ;
      S_SETUP:  w_next = S_STROBE;
      S_STROBE: begin
        for (int k = 0; k < NUM_WORDS; k++) begin
          if (r_addr == ADDR_W'(k)) w_mem_e[k] = 1'b1;
        end
        if (r_cnt == 4'd0) w_next = S_HOLD;
      end
`ifdef LATCH_BANK_VERIFY_EN
      S_HOLD:   w_next = S_VERIFY;
      S_VERIFY: w_next = S_ACK;
`else
      S_HOLD:   w_next = S_ACK;
`endif
      S_READ:   w_next = S_ACK;
      S_ACK:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Capture the winner's request, update round-robin history, pulse gnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= 8'h00;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
    end else begin
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      if (r_state == S_IDLE && w_any) begin
        r_owner_b <= !w_pick_a;
        r_last_b  <= !w_pick_a;
        r_addr    <= w_win_addr;
        r_wdata   <= w_win_wdata;
        r_gnt_a   <= w_pick_a;
        r_gnt_b   <= !w_pick_a;
      end
    end
  end

  // Strobe dwell counter: loaded in SETUP, counts down through STROBE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (r_state == S_SETUP) begin
      r_cnt <= 4'(EN_CYCLES - 1);
    end else if (r_state == S_STROBE && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Data bus is loaded as SETUP begins so it leads the strobe by one cycle;
  // it then holds until the next write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_d <= 8'h00;
    end else if (r_state == S_IDLE && w_any && w_win_we) begin
      r_mem_d <= w_win_wdata;
    end
  end

  // Read result is captured in READ and held until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 8'h00;
    end else if (r_state == S_READ) begin
      r_rdata <= word_sel(mem_Q, r_addr);
    end
  end

`ifdef LATCH_BANK_VERIFY_EN
  logic r_err;

  // True when address a maps onto a real word.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (a == ADDR_W'(k)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Sticky read-back error; out-of-range writes are not compared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == S_VERIFY && in_range(r_addr) &&
                 word_sel(mem_Q, r_addr) != r_wdata) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign gnt_a  = r_gnt_a;
  assign gnt_b  = r_gnt_b;
  assign done_a = (r_state == S_ACK) && !r_owner_b;
  assign done_b = (r_state == S_ACK) &&  r_owner_b;
  assign rdata  = r_rdata;
  assign mem_D  = r_mem_d;
  assign mem_E  = w_mem_e;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Testbench for latch_bank_ctrl: a default instance (4 words, 1-cycle strobe)
// and an alternate instance (3 words, 3-cycle strobe), each with a
// behavioural latch bank model. Honors LATCH_BANK_VERIFY_EN if defined.
module tb_latch_bank_ctrl;

`ifdef LATCH_BANK_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif
  localparam int WLAT  = 4 + VX;  // write latency, EN_CYCLES = 1
  localparam int WLAT3 = 6 + VX;  // write latency, EN_CYCLES = 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [1:0]  addr_a, addr_b;
  logic [7:0]  wdata_a, wdata_b;
  logic        gnt_a, done_a, gnt_b, done_b, busy, err;
  logic [7:0]  rdata, mem_D;
  logic [3:0]  mem_E;
  logic [31:0] mem_Q;
  logic        force_q0;

  logic        x_req_a, x_we_a;
  logic [1:0]  x_addr_a;
  logic [7:0]  x_wdata_a;
  logic        x_gnt_a, x_done_a, x_gnt_b, x_done_b, x_busy, x_err;
  logic [7:0]  x_rdata, x_mem_D;
  logic [2:0]  x_mem_E;
  logic [23:0] x_mem_Q;

  latch_bank_ctrl #(.NUM_WORDS(4), .ADDR_W(2), .EN_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .done_a(done_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .done_b(done_b),
    .rdata(rdata), .mem_D(mem_D), .mem_E(mem_E), .mem_Q(mem_Q),
    .busy(busy), .err(err)
  );

  latch_bank_ctrl #(.NUM_WORDS(3), .ADDR_W(2), .EN_CYCLES(3)) u_alt (
    .clk(clk), .reset(reset),
    .req_a(x_req_a), .we_a(x_we_a), .addr_a(x_addr_a), .wdata_a(x_wdata_a),
    .gnt_a(x_gnt_a), .done_a(x_done_a),
    .req_b(1'b0), .we_b(1'b0), .addr_b(2'd0), .wdata_b(8'h00),
    .gnt_b(x_gnt_b), .done_b(x_done_b),
    .rdata(x_rdata), .mem_D(x_mem_D), .mem_E(x_mem_E), .mem_Q(x_mem_Q),
    .busy(x_busy), .err(x_err)
  );

  // Behavioural level-sensitive latch banks.
  logic [7:0] q_d [4];
  logic [7:0] q_x [3];
  always @(mem_E or mem_D)
    for (int k = 0; k < 4; k++) if (mem_E[k]) q_d[k] = mem_D;
  always @(x_mem_E or x_mem_D)
    for (int k = 0; k < 3; k++) if (x_mem_E[k]) q_x[k] = x_mem_D;
  assign mem_Q   = {q_d[3], q_d[2], q_d[1], force_q0 ? 8'h00 : q_d[0]};
  assign x_mem_Q = {q_x[2], q_x[1], q_x[0]};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on the default instance by requester sel (0 = A, 1 = B).
  task automatic run_access(input bit sel, input bit we, input logic [1:0] addr,
                            input logic [7:0] wd, output int lat, output int gcyc,
                            output int ecnt, output logic [3:0] eor,
                            output logic [7:0] rd);
    lat = 0; gcyc = 0; ecnt = 0; eor = 4'b0; rd = 8'h00;
    if (!sel) begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    else      begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if ((!sel && gnt_a) || (sel && gnt_b)) gcyc = c;
      if (mem_E != 4'b0) begin ecnt++; eor |= mem_E; end
      if ((!sel && done_a) || (sel && done_b)) begin lat = c; rd = rdata; end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  // Simultaneous A and B requests; each drops req right after its done.
  task automatic run_pair(input bit wa, input logic [1:0] aa, input logic [7:0] da,
                          input bit wb, input logic [1:0] ab, input logic [7:0] db,
                          output int ga, output int gb, output int dna, output int dnb,
                          output logic [7:0] ra, output logic [7:0] rb);
    ga = 0; gb = 0; dna = 0; dnb = 0; ra = 8'h00; rb = 8'h00;
    req_a = 1'b1; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = 1'b1; we_b = wb; addr_b = ab; wdata_b = db;
    for (int c = 1; c <= 30 && (dna == 0 || dnb == 0); c++) begin
      tick();
      if (gnt_a) ga = c;
      if (gnt_b) gb = c;
      if (done_a) begin dna = c; ra = rdata; req_a = 1'b0; end
      if (done_b) begin dnb = c; rb = rdata; req_b = 1'b0; end
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
  endtask

  // One access on the alternate instance.
  task automatic run_alt(input bit we, input logic [1:0] addr, input logic [7:0] wd,
                         output int lat, output int ecnt, output logic [2:0] eor,
                         output logic [7:0] rd);
    lat = 0; ecnt = 0; eor = 3'b0; rd = 8'h00;
    x_req_a = 1'b1; x_we_a = we; x_addr_a = addr; x_wdata_a = wd;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      tick();
      if (x_mem_E != 3'b0) begin ecnt++; eor |= x_mem_E; end
      if (x_done_a) begin lat = c; rd = x_rdata; end
    end
    x_req_a = 1'b0;
    tick();
  endtask

  typedef struct {
    bit         sel;
    bit         we;
    logic [1:0] addr;
    logic [7:0] wd;
    int         exp_lat;
    logic [3:0] exp_e;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vt [9];

  initial begin
    int lat, gcyc, ecnt, ga, gb, dna, dnb;
    logic [3:0] eor;
    logic [2:0] xeor;
    logic [7:0] rd, ra, rb;
    bit seen;

    vt[0] = '{1'b0, 1'b1, 2'd2, 8'hA5, WLAT, 4'b0100, 8'h00};
    vt[1] = '{1'b0, 1'b0, 2'd2, 8'h00, 2,    4'b0000, 8'hA5};
    vt[2] = '{1'b1, 1'b1, 2'd3, 8'h5A, WLAT, 4'b1000, 8'h00};
    vt[3] = '{1'b1, 1'b0, 2'd3, 8'h00, 2,    4'b0000, 8'h5A};
    vt[4] = '{1'b0, 1'b1, 2'd1, 8'hC3, WLAT, 4'b0010, 8'h00};
    vt[5] = '{1'b1, 1'b0, 2'd1, 8'h00, 2,    4'b0000, 8'hC3};
    vt[6] = '{1'b0, 1'b0, 2'd2, 8'h00, 2,    4'b0000, 8'hA5};
    vt[7] = '{1'b1, 1'b1, 2'd2, 8'h0F, WLAT, 4'b0100, 8'h00};
    vt[8] = '{1'b0, 1'b0, 2'd2, 8'h00, 2,    4'b0000, 8'h0F};

    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    x_req_a = 0; x_we_a = 0; x_addr_a = 0; x_wdata_a = 0;
    force_q0 = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_ctl", {gnt_a, gnt_b, done_a, done_b, busy, err}, 32'h0);
    chk("rst_data", {rdata, mem_D, mem_E}, 32'h0);
    chk("rst_alt", {x_busy, x_err, x_mem_E, x_mem_D}, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Write A5 to word 2, cycle by cycle.
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd2; wdata_a = 8'hA5;
    tick();
    chk("t1_c1_gnt_busy", {gnt_a, gnt_b, busy}, 32'b101);
    chk("t1_c1_setup", {mem_E, mem_D}, {4'b0000, 8'hA5});
    wdata_a = 8'h00; addr_a = 2'd0;  // post-grant changes must be ignored
    tick();
    chk("t1_c2_strobe", {gnt_a, mem_E, mem_D}, {1'b0, 4'b0100, 8'hA5});
    tick();
    chk("t1_c3_hold", {mem_E, mem_D}, {4'b0000, 8'hA5});
    if (VX == 1) tick();
    tick();
    chk("t1_done", {done_a, done_b}, 32'b10);
    req_a = 1'b0;
    tick();
    chk("t1_idle", {done_a, busy, mem_D}, {2'b00, 8'hA5});
    run_access(1'b0, 1'b0, 2'd2, 8'h00, lat, gcyc, ecnt, eor, rd);
    chk("t1_rd_lat", lat, 2);
    chk("t1_rd_data", rd, 8'hA5);

    for (int i = 0; i < 9; i++) begin
      run_access(vt[i].sel, vt[i].we, vt[i].addr, vt[i].wd, lat, gcyc, ecnt, eor, rd);
      chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("v%0d_gnt", i), gcyc, 1);
      chk($sformatf("v%0d_en", i), {ecnt[3:0], eor}, {(vt[i].we ? 4'd1 : 4'd0), vt[i].exp_e});
      if (!vt[i].we) chk($sformatf("v%0d_rd", i), rd, vt[i].exp_rd);
    end
    chk("rdata_held", rdata, 8'h0F);

    // Tie after reset: A wins, then B.
    reset = 1'b1; tick(); reset = 1'b0; tick();
    run_pair(1'b1, 2'd0, 8'h11, 1'b1, 2'd1, 8'h22, ga, gb, dna, dnb, ra, rb);
    chk("tie1_gnt", {ga[7:0], gb[7:0]}, {8'd1, 8'(WLAT + 2)});
    chk("tie1_done", {dna[7:0], dnb[7:0]}, {8'(WLAT), 8'(2 * WLAT + 1)});
    run_access(1'b0, 1'b0, 2'd0, 8'h00, lat, gcyc, ecnt, eor, rd);
    chk("solo_a_rd", rd, 8'h11);
    // Last grant is now A, so B wins the read tie.
    run_pair(1'b0, 2'd0, 8'h00, 1'b0, 2'd1, 8'h00, ga, gb, dna, dnb, ra, rb);
    chk("tie2_order", {gb[7:0], dnb[7:0], ga[7:0], dna[7:0]}, {8'd1, 8'd2, 8'd4, 8'd5});
    chk("tie2_data", {rb, ra}, {8'h22, 8'h11});

    // Reset in the middle of the strobe.
    req_a = 1'b1; we_a = 1'b1; addr_a = 2'd0; wdata_a = 8'h77;
    tick(); tick();
    chk("rs_strobe", mem_E, 4'b0001);
    #2 reset = 1'b1;
    #1;
    chk("rs_async", {mem_E, busy, done_a}, 32'h0);
    req_a = 1'b0;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done_a || done_b || busy) seen = 1'b1;
    end
    chk("rs_no_done", seen, 1'b0);
    run_access(1'b0, 1'b1, 2'd0, 8'h3C, lat, gcyc, ecnt, eor, rd);
    chk("rs_wr", {lat[7:0], eor}, {8'(WLAT), 4'b0001});
    run_access(1'b1, 1'b0, 2'd0, 8'h00, lat, gcyc, ecnt, eor, rd);
    chk("rs_rd", rd, 8'h3C);

`ifdef LATCH_BANK_VERIFY_EN
    force_q0 = 1'b1;
    run_access(1'b0, 1'b1, 2'd0, 8'h3C, lat, gcyc, ecnt, eor, rd);
    chk("vf_lat", lat, 5);
    chk("vf_err_set", err, 1'b1);
    force_q0 = 1'b0;
    run_access(1'b0, 1'b1, 2'd1, 8'h96, lat, gcyc, ecnt, eor, rd);
    chk("vf_err_sticky", {lat[7:0], err}, {8'd5, 1'b1});
`else
    chk("err_tied", err, 1'b0);
`endif

    // Alternate instance: out-of-range word and 3-cycle strobe.
    run_alt(1'b1, 2'd3, 8'hFF, lat, ecnt, xeor, rd);
    chk("oor_wr_lat", lat, WLAT3);
    chk("oor_wr_en", {ecnt[3:0], xeor, x_mem_D}, {4'd0, 3'b000, 8'hFF});
    run_alt(1'b0, 2'd3, 8'h00, lat, ecnt, xeor, rd);
    chk("oor_rd", {lat[7:0], rd}, {8'd2, 8'h00});
    run_alt(1'b1, 2'd1, 8'h55, lat, ecnt, xeor, rd);
    chk("en3_lat", lat, WLAT3);
    chk("en3_en", {ecnt[3:0], xeor}, {4'd3, 3'b010});
    run_alt(1'b0, 2'd1, 8'h00, lat, ecnt, xeor, rd);
    chk("en3_rd", rd, 8'h55);
    chk("alt_err", x_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
